numarator_ceas: RTL
===================

# numarator_ceas

Time-of-day counter for the clock design. It divides the system clock down to a 1 Hz tick and keeps seconds, minutes and hours in binary. It also supports a two-step manual set mode driven by two pre-debounced button pulses. Its `sec`, `min` and `hour` outputs feed directly into the per-field tens/units digit splitters, and from there the display drivers.

## Interface

Parameters:
- `TICKS_PER_SEC`, default 50_000_000: clk cycles per second. Must be ≥ 2; the bench uses 4.
- `PW`, default 26: prescaler width. Must satisfy 2^PW ≥ TICKS_PER_SEC.

Ports (all synchronous to `clk`):
- `clk` input, 1 bit: system clock. One clock only; rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `btn_mode` input, 1 bit: one-cycle pulse, already debounced; advances the mode.
- `btn_inc` input, 1 bit: one-cycle pulse, already debounced; increments the field selected by the current mode.
- `sec` output, 6 bits: seconds, 0–59, registered.
- `min` output, 6 bits: minutes, 0–59, registered.
- `hour` output, 6 bits: hours, 0–23, registered.
- `mode` output, 2 bits: 0 = RUN, 1 = SET_H, 2 = SET_M; registered.
- `tick_1hz` output, 1 bit: one-cycle pulse, high in the same cycle a new `sec` value first appears.

## Operation

- **Reset** (`rst` = 1 at an edge):
  - `sec`, `min`, `hour` = 0; prescaler = 0; `mode` = RUN; `tick_1hz` = 0.
  - Reset overrides every other input in that cycle.
  - Reset in mid-operation, including inside a set mode, returns to RUN at 00:00:00.
- **State machine**, on `btn_mode`: RUN → SET_H → SET_M → RUN. Encoding 2'd3 is unreachable; if ever held, the next edge goes to RUN.
- **RUN state:**
  - Prescaler counts 0 … TICKS_PER_SEC−1, then wraps to 0.
  - On the wrap edge, `sec` increments; 59 → 0 carries into `min`.
  - `min` 59 → 0 carries into `hour`; `hour` 23 → 0 with no further carry.
  - Full rollover: 23:59:59 → 00:00:00 in one edge.
  - `btn_inc` is ignored.
- **Entering SET_H** (RUN + `btn_mode`): `sec` is cleared to 0 and the prescaler is cleared to 0 on that same edge.
- **SET_H state:**
  - Time is frozen and the prescaler is held at 0.
  - `btn_inc`: `hour` +1, wrapping 23 → 0.
- **SET_M state:**
  - `btn_inc`: `min` +1, wrapping 59 → 0.
  - No carry into `hour`; `sec` is untouched.
- **Returning to RUN** (SET_M + `btn_mode`): the prescaler restarts from 0. The first increment of `sec` occurs TICKS_PER_SEC cycles after the mode edge.
- **Simultaneous `btn_mode` and `btn_inc`:** mode wins and `btn_inc` is discarded.
- **Arithmetic:** all fields are unsigned 6-bit and compared against constants. Out-of-range values are unreachable from reset; no saturation logic is required.

## Timing

- All outputs are registered with no combinational paths from input to output.
- **RUN:**
  - Let edge E be the one where the prescaler equals TICKS_PER_SEC−1.
  - After E: the new `sec` (plus any carried `min`/`hour`) is visible and `tick_1hz` = 1 for exactly one cycle.
  - Period between `tick_1hz` pulses: exactly TICKS_PER_SEC cycles.
- **Buttons:** a pulse sampled at edge N changes `mode` or the field value visible after edge N, i.e. latency 1.
- **Set modes:** `tick_1hz` stays 0 throughout.

## Structure

- **Shared package** (`ceas_pkg`):
  - Mode encoding constants MODE_RUN, MODE_SET_H, MODE_SET_M.
  - Field limits SEC_MAX = 59, MIN_MAX = 59, HOUR_MAX = 23.
  - The digit splitters reuse the same limits.
- **Sub-module `contor_modulo`** (parameter MAX):
  - Inputs: `clk`, `rst`, `clr`, `en`. Outputs: 6-bit `q`, `carry`.
  - `carry` is combinational and equals `en` && (`q` == MAX).
  - Instantiated three times.
  - In set modes, the parent drives `en` from `btn_inc` and masks the carry.
- **Top level:** prescaler and mode FSM.

## Test plan

Each line: stimulus → required response, with TICKS_PER_SEC = 4.

1. **Reset:** hold `rst` for 2 cycles → `sec`/`min`/`hour` = 0, `mode` = 0, `tick_1hz` = 0. Then release → first `tick_1hz` 4 cycles after release with `sec` = 1; pulses recur every 4 cycles.
2. **Rollover:** preset via set mode to 23:59, return to RUN, run 59 s → display 23:59:59. One further tick → 00:00:00 in a single cycle, with `tick_1hz` high.
3. **Set hours:** `btn_mode` → `mode` = 1 and `sec` = 0. Then 25 `btn_inc` pulses from `hour` = 0 → `hour` = 1, `min` unchanged, `tick_1hz` never asserted.
4. **Set minutes:** in SET_M at `min` = 59 with `hour` = 5, pulse `btn_inc` → `min` = 0, `hour` stays 5. Then `btn_mode` → RUN; first tick exactly 4 cycles later.
5. **Simultaneous buttons and unused encoding:**
   - In RUN, pulse `btn_mode` and `btn_inc` together → `mode` = 1 with no field change.
   - In SET_H, pulse both together → `mode` = 2 and `hour` unchanged.
   - Force `mode` = 3 → RUN on the next edge.
6. **Reset mid-operation:** assert `rst` while in SET_M at 12:34 → next cycle shows `mode` = 0 and 00:00:00, and the prescaler restarts, giving the first tick 4 cycles after release.

Source files
------------

// File: rtl/ceas_pkg.sv
// ceas_pkg: mode encodings and field limits shared by the time-of-day counter and digit splitters
package ceas_pkg;
  localparam logic [1:0] MODE_RUN   = 2'd0;
  localparam logic [1:0] MODE_SET_H = 2'd1;
  localparam logic [1:0] MODE_SET_M = 2'd2;
  localparam logic [5:0] SEC_MAX    = 6'd59;
  localparam logic [5:0] MIN_MAX    = 6'd59;
  localparam logic [5:0] HOUR_MAX   = 6'd23;
endpackage

// File: rtl/contor_modulo.sv
// contor_modulo: 6-bit wrap-at-MAX counter with sync clear and a combinational carry
module contor_modulo #(
  parameter logic [5:0] MAX = 6'd59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [5:0] q,
  output logic       carry
);
  assign carry = en && (q == MAX);
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (en) q <= (q == MAX) ? '0 : q + 6'd1;
endmodule

// File: rtl/numarator_ceas.sv
// numarator_ceas: 1 Hz prescaler, hh:mm:ss counter chain and RUN/SET_H/SET_M button FSM
module numarator_ceas
  import ceas_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int PW = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [5:0] hour,
  output logic [1:0] mode,
  output logic       tick_1hz
);
  logic [PW-1:0] presc;
  logic run, wrap, adv, sec_c, min_c;
  assign run  = mode == MODE_RUN;
  assign wrap = run && (presc == PW'(TICKS_PER_SEC - 1));
  // a mode press on the wrap edge wins: the second is dropped, not counted
  assign adv  = wrap && !btn_mode;
  contor_modulo #(.MAX(SEC_MAX)) u_sec (
    .clk, .rst, .clr(run && btn_mode), .en(adv), .q(sec), .carry(sec_c)
  );
  contor_modulo #(.MAX(MIN_MAX)) u_min (
    .clk, .rst, .clr(1'b0),
    .en(run ? sec_c : (mode == MODE_SET_M) && btn_inc && !btn_mode),
    .q(min), .carry(min_c)
  );
  contor_modulo #(.MAX(HOUR_MAX)) u_hour (
    .clk, .rst, .clr(1'b0),
    .en(run ? min_c : (mode == MODE_SET_H) && btn_inc && !btn_mode),
    .q(hour), .carry()
  );
  always_ff @(posedge clk)
    if (rst) begin
      mode     <= MODE_RUN;
      presc    <= '0;
      tick_1hz <= 1'b0;
    end else begin
      mode     <= btn_mode ? (run ? MODE_SET_H : (mode == MODE_SET_H) ? MODE_SET_M : MODE_RUN)
                           : ((mode == 2'd3) ? MODE_RUN : mode);
      presc    <= (!run || btn_mode || wrap) ? '0 : presc + 1'b1;
      tick_1hz <= adv;
    end
endmodule
